// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants and the alignment state type for the per-channel decoder.
package tmds_pkg;

   typedef enum logic [1:0] {
      SEARCH    = 2'd0,
      SLIP_WAIT = 2'd1,
      LOCKED    = 2'd2
   } tmds_align_state_t;

   // Control tokens indexed by {c1,c0}, written q[9:0].
   localparam logic [9:0] CTRL_TOKEN [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };

   // TERC4 code words indexed by the nibble they carry, written q[9:0].
   localparam logic [9:0] TERC4_CODE [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   // Video guard band symbols (the first one is also TERC4 code 8).
   localparam logic [9:0] GUARD_VIDEO_A = 10'b1011001100;
   localparam logic [9:0] GUARD_VIDEO_B = 10'b0100110011;

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Symbol stream and decode results of one TMDS channel.
// There is no valid/ready handshake: the deserializer presents one symbol every
// clk_pixel cycle and the decoder never back-pressures; bitslip is a single-cycle
// request back to the deserializer to move its word boundary by one bit.
interface tmds_channel_decoder_if;
   import tmds_pkg::*;

   logic [9:0]        tmds_raw;
   logic              bitslip;
   logic              locked;
   logic [3:0]        slip_count;
   logic [7:0]        video_data;
   logic [1:0]        control;
   logic [3:0]        terc4_data;
   logic              is_control;
   logic              is_terc4;
   logic              is_guard;
   tmds_align_state_t align_state;

   // Deserializer / downstream side.
   modport master (
      output tmds_raw,
      input  bitslip, locked, slip_count, video_data, control, terc4_data,
             is_control, is_terc4, is_guard, align_state
   );

   // Decoder side.
   modport slave (
      input  tmds_raw,
      output bitslip, locked, slip_count, video_data, control, terc4_data,
             is_control, is_terc4, is_guard, align_state
   );
endinterface

// File: rtl/tmds_symbol_decode.sv
// Purely combinational classification and decode of one 10-bit TMDS symbol.
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [9:0] sym,
   output logic [7:0] video_data,
   output logic [1:0] control,
   output logic [3:0] terc4_data,
   output logic       is_control,
   output logic       is_terc4,
   output logic       is_guard
);

   logic [7:0] d;

   // Undo the optional inversion, then the XOR/XNOR transition chain.
   always_comb begin
      d = sym[9] ? ~sym[7:0] : sym[7:0];
      video_data    = '0;
      video_data[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         video_data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
   end

   // Table lookups; the fields stay zero unless their flag is set.
   always_comb begin
      is_control = 1'b0;
      control    = 2'b00;
      is_terc4   = 1'b0;
      terc4_data = 4'h0;
      for (int i = 0; i < 4; i++) begin
         if (sym == CTRL_TOKEN[i]) begin
            is_control = 1'b1;
            control    = 2'(i);
         end
      end
      for (int i = 0; i < 16; i++) begin
         if (sym == TERC4_CODE[i]) begin
            is_terc4   = 1'b1;
            terc4_data = 4'(i);
         end
      end
      is_guard = (sym == GUARD_VIDEO_A) || (sym == GUARD_VIDEO_B);
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel: registered symbol decode plus control-token based word alignment
// that drives bitslip requests into the deserializer until control runs appear.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int CTRL_RUN      = 8,
   parameter int SEARCH_CYCLES = 2048,
   parameter int SLIP_SETTLE   = 4
) (
   input  logic                  clk_pixel,
   input  logic                  reset,
   tmds_channel_decoder_if.slave tmds
);

   localparam int RUN_W = $clog2(CTRL_RUN + 1);
   localparam int WIN_W = $clog2(SEARCH_CYCLES + 1);
   localparam int SET_W = $clog2(SLIP_SETTLE + 1);

   logic [7:0]        dec_video;
   logic [1:0]        dec_control;
   logic [3:0]        dec_terc4;
   logic              dec_is_control;
   logic              dec_is_terc4;
   logic              dec_is_guard;

   tmds_align_state_t state;
   tmds_align_state_t state_nxt;
   logic              slip_nxt;
   logic              qualify;
   logic              timeout;
   logic [RUN_W-1:0]  run_cnt;
   logic [WIN_W-1:0]  win_cnt;
   logic [SET_W-1:0]  settle_cnt;

   tmds_symbol_decode u_decode (
      .sym        (tmds.tmds_raw),
      .video_data (dec_video),
      .control    (dec_control),
      .terc4_data (dec_terc4),
      .is_control (dec_is_control),
      .is_terc4   (dec_is_terc4),
      .is_guard   (dec_is_guard)
   );

   // A run qualifies exactly once, on the token that brings run_cnt up to CTRL_RUN.
   assign qualify = (state != SLIP_WAIT) && dec_is_control && (run_cnt == RUN_W'(CTRL_RUN - 1));
   assign timeout = (win_cnt == WIN_W'(SEARCH_CYCLES - 1));

   assign tmds.locked      = (state == LOCKED);
   assign tmds.align_state = state;

   // Decoded fields: the only register between tmds_raw and the outputs (latency 1).
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         tmds.video_data <= '0;
         tmds.control    <= '0;
         tmds.terc4_data <= '0;
         tmds.is_control <= 1'b0;
         tmds.is_terc4   <= 1'b0;
         tmds.is_guard   <= 1'b0;
      end else begin
         tmds.video_data <= dec_video;
         tmds.control    <= dec_control;
         tmds.terc4_data <= dec_terc4;
         tmds.is_control <= dec_is_control;
         tmds.is_terc4   <= dec_is_terc4;
         tmds.is_guard   <= dec_is_guard;
      end
   end

   // Alignment next-state: a qualifying run always beats a coincident timeout.
   always_comb begin
      state_nxt = state;
      slip_nxt  = 1'b0;
      case (state)
         SEARCH: begin
            if (qualify) begin
               state_nxt = LOCKED;
            end else if (timeout) begin
               state_nxt = SLIP_WAIT;
               slip_nxt  = 1'b1;
            end
         end
         SLIP_WAIT: begin
            if (settle_cnt == SET_W'(SLIP_SETTLE - 1)) state_nxt = SEARCH;
         end
         LOCKED: begin
            if (!qualify && timeout) state_nxt = SEARCH;
         end
         default: state_nxt = SEARCH;
      endcase
   end

   // State register, bitslip pulse and the decimal-wrapping slip counter.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         state           <= SEARCH;
         tmds.bitslip    <= 1'b0;
         tmds.slip_count <= 4'd0;
      end else begin
         state        <= state_nxt;
         tmds.bitslip <= slip_nxt;
         if (state == SEARCH && qualify) begin
            tmds.slip_count <= 4'd0;
         end else if (slip_nxt) begin
            tmds.slip_count <= (tmds.slip_count == 4'd9) ? 4'd0 : tmds.slip_count + 4'd1;
         end
      end
   end

   // Run, window and settle counters; symbols seen while settling are ignored.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         run_cnt    <= '0;
         win_cnt    <= '0;
         settle_cnt <= '0;
      end else begin
         if (state == SLIP_WAIT || state_nxt == SLIP_WAIT) begin
            run_cnt <= '0;
         end else if (dec_is_control) begin
            if (run_cnt != RUN_W'(CTRL_RUN)) run_cnt <= run_cnt + RUN_W'(1);
         end else begin
            run_cnt <= '0;
         end

         if (state == SLIP_WAIT || state_nxt != state || qualify) win_cnt <= '0;
         else                                                     win_cnt <= win_cnt + WIN_W'(1);

         if (state == SLIP_WAIT) settle_cnt <= settle_cnt + SET_W'(1);
         else                    settle_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: decode tables, alignment, unlock and reset cases.
module tb_tmds_channel_decoder;

   localparam int CR = 8;
   localparam int SC = 2048;
   localparam int SS = 4;

   localparam logic [9:0] T00    = 10'b1101010100;
   localparam logic [9:0] FILLER = 10'b0000011111;
   localparam logic [9:0] CTRL_TAB [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };
   localparam logic [9:0] TERC4_TAB [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };
   localparam logic [31:0] ST_SEARCH = 32'd0;
   localparam logic [31:0] ST_SLIP   = 32'd1;
   localparam logic [31:0] ST_LOCKED = 32'd2;

   logic clk_pixel = 1'b0;
   logic reset     = 1'b1;
   int   checks    = 0;
   int   errors    = 0;
   logic [7:0] exp_q [$];

   tmds_channel_decoder_if bus_if ();

   tmds_channel_decoder #(
      .CTRL_RUN      (CR),
      .SEARCH_CYCLES (SC),
      .SLIP_SETTLE   (SS)
   ) dut (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .tmds      (bus_if)
   );

   // Clock / reset
   always #5 clk_pixel = ~clk_pixel;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic drive(input logic [9:0] sym);
      bus_if.tmds_raw = sym;
      step();
   endtask

   // One reset edge, then every output must be back at its reset value.
   task automatic apply_reset(input string tag);
      reset = 1'b1;
      step();
      check_eq({tag, "_outs"}, 32'({bus_if.bitslip, bus_if.locked, bus_if.slip_count,
               bus_if.video_data, bus_if.control, bus_if.terc4_data,
               bus_if.is_control, bus_if.is_terc4, bus_if.is_guard}), 32'd0);
      check_eq({tag, "_state"}, 32'(bus_if.align_state), ST_SEARCH);
      reset = 1'b0;
   endtask

   // Reference TMDS encoder; disp is the running disparity going in.
   function automatic logic [9:0] tmds_encode(input logic [7:0] d, input int disp);
      logic [8:0] qm;
      int n1d, n1q;
      n1d   = $countones(d);
      qm[0] = d[0];
      if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
         qm[8] = 1'b1;
      end
      n1q = $countones(qm[7:0]);
      if (disp == 0 || n1q == 4)
         return {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      else if ((disp > 0 && n1q > 4) || (disp < 0 && n1q < 4))
         return {1'b1, qm[8], ~qm[7:0]};
      else
         return {1'b0, qm[8], qm[7:0]};
   endfunction

   // Wire-level source: 10 control tokens then 2 filler symbols, repeating.
   function automatic logic [9:0] stream_sym(input int k);
      return ((k % 12) < 10) ? T00 : FILLER;
   endfunction

   // Deserializer model: word starts ph bits into symbol k of the serial stream.
   function automatic logic [9:0] stream_word(input int k, input int ph);
      logic [19:0] two;
      two = {stream_sym(k + 1), stream_sym(k)};
      two = two >> ph;
      return two[9:0];
   endfunction

   // Stimulus and checks
   initial begin
      int ph, n, cyc, slips, max_sc, drops, pulses, j;
      int slip_at [4];
      bus_if.tmds_raw = 10'd0;
      repeat (2) @(posedge clk_pixel);
      #1;
      apply_reset("reset0");

      // Hand-decoded video vectors.
      drive(10'h100); check_eq("vid_hand_100", 32'(bus_if.video_data), 32'h00);
      drive(10'h2FF); check_eq("vid_hand_2ff", 32'(bus_if.video_data), 32'hFE);
      drive(10'h1FF); check_eq("vid_hand_1ff", 32'(bus_if.video_data), 32'h01);

      // Every byte through both disparity branches of the encoder.
      for (int v = 0; v < 256; v++) begin
         for (int p = 0; p < 2; p++) begin
            exp_q.push_back(8'(v));
            drive(tmds_encode(8'(v), (p == 0) ? 4 : -4));
            check_eq($sformatf("video_%0h_%0d", v, p), 32'(bus_if.video_data), 32'(exp_q.pop_front()));
         end
      end

      // Control tokens, TERC4 codes, second guard symbol and an illegal symbol.
      // Compared field: {is_control, is_terc4, is_guard, control, terc4_data}.
      for (int i = 0; i < 4; i++) begin
         drive(CTRL_TAB[i]);
         check_eq($sformatf("ctrl_%0d", i), 32'({bus_if.is_control, bus_if.is_terc4, bus_if.is_guard,
                  bus_if.control, bus_if.terc4_data}), 32'({1'b1, 1'b0, 1'b0, 2'(i), 4'h0}));
      end
      for (int i = 0; i < 16; i++) begin
         drive(TERC4_TAB[i]);
         check_eq($sformatf("terc4_%0d", i), 32'({bus_if.is_control, bus_if.is_terc4, bus_if.is_guard,
                  bus_if.control, bus_if.terc4_data}), 32'({1'b0, 1'b1, (i == 8), 2'b00, 4'(i)}));
      end
      drive(10'b0100110011);
      check_eq("guard_b", 32'({bus_if.is_control, bus_if.is_terc4, bus_if.is_guard,
               bus_if.control, bus_if.terc4_data}), 32'({1'b0, 1'b0, 1'b1, 2'b00, 4'h0}));
      drive(10'h3FF);
      check_eq("illegal_3ff", 32'({bus_if.is_control, bus_if.is_terc4, bus_if.is_guard,
               bus_if.control, bus_if.terc4_data}), 32'd0);

      // Alignment from a stream whose word boundary is 7 bits in: three slips reach it.
      apply_reset("t3_rst");
      ph = 7; n = 0; cyc = 0; slips = 0; max_sc = 0;
      for (int i = 0; i < 4; i++) slip_at[i] = 0;
      while (bus_if.locked !== 1'b1 && cyc < 3 * (SC + SS + 1) + CR + 12) begin
         drive(stream_word(n, ph));
         cyc++;
         n++;
         if (bus_if.bitslip === 1'b1) begin
            if (slips < 4) slip_at[slips] = cyc;
            slips++;
            ph++;
            if (ph == 10) begin
               ph = 0;
               n++;
            end
         end
         if (int'(bus_if.slip_count) > max_sc) max_sc = int'(bus_if.slip_count);
      end
      check_eq("t3_locked", 32'(bus_if.locked), 32'd1);
      check_eq("t3_slips", 32'(slips), 32'd3);
      check_eq("t3_first_slip", 32'(slip_at[0]), 32'(SC));
      check_eq("t3_gap1", 32'(slip_at[1] - slip_at[0]), 32'(SC + SS));
      check_eq("t3_gap2", 32'(slip_at[2] - slip_at[1]), 32'(SC + SS));
      check_eq("t3_max_count", 32'(max_sc), 32'd3);
      check_eq("t3_count_after_lock", 32'(bus_if.slip_count), 32'd0);

      // Fresh qualify, then runs one token short: lock ages out, slip only a window later.
      drive(FILLER);
      for (int k = 0; k < CR; k++) drive(T00);
      check_eq("t4_fresh_lock", 32'(bus_if.locked), 32'd1);
      j = 0; drops = 0; pulses = 0;
      for (int k = 0; k < SC - 1; k++) begin
         drive(((j % 8) < 7) ? T00 : FILLER);
         j++;
         if (bus_if.locked !== 1'b1) drops++;
      end
      check_eq("t4_hold", 32'(drops), 32'd0);
      drive(((j % 8) < 7) ? T00 : FILLER);
      j++;
      check_eq("t4_unlock", 32'(bus_if.locked), 32'd0);
      check_eq("t4_unlock_state", 32'(bus_if.align_state), ST_SEARCH);
      check_eq("t4_unlock_noslip", 32'(bus_if.bitslip), 32'd0);
      for (int k = 0; k < SC - 1; k++) begin
         drive(((j % 8) < 7) ? T00 : FILLER);
         j++;
         if (bus_if.bitslip === 1'b1) pulses++;
      end
      check_eq("t4_no_early_slip", 32'(pulses), 32'd0);
      drive(((j % 8) < 7) ? T00 : FILLER);
      check_eq("t4_slip", 32'(bus_if.bitslip), 32'd1);
      check_eq("t4_slip_state", 32'(bus_if.align_state), ST_SLIP);
      check_eq("t4_slip_count", 32'(bus_if.slip_count), 32'd1);

      // Reset while the bitslip pulse is high.
      apply_reset("t6_slip");

      // Qualifying run whose last token lands on the timeout cycle.
      pulses = 0;
      for (int k = 0; k < SC - CR; k++) begin
         drive(FILLER);
         if (bus_if.bitslip === 1'b1) pulses++;
      end
      for (int k = 0; k < CR - 1; k++) begin
         drive(T00);
         if (bus_if.bitslip === 1'b1) pulses++;
      end
      check_eq("t5_not_yet", 32'(bus_if.locked), 32'd0);
      drive(T00);
      check_eq("t5_locked", 32'(bus_if.locked), 32'd1);
      check_eq("t5_state", 32'(bus_if.align_state), ST_LOCKED);
      check_eq("t5_no_slip", 32'(bus_if.bitslip), 32'd0);
      drive(FILLER);
      check_eq("t5_no_slip_after", 32'(bus_if.bitslip), 32'd0);
      check_eq("t5_no_pulse_before", 32'(pulses), 32'd0);

      // Reset while locked, then relock from SEARCH.
      apply_reset("t6_locked");
      drive(FILLER);
      for (int k = 0; k < CR - 1; k++) drive(T00);
      check_eq("t6_relock_short", 32'(bus_if.locked), 32'd0);
      drive(T00);
      check_eq("t6_relock", 32'(bus_if.locked), 32'd1);
      check_eq("t6_relock_count", 32'(bus_if.slip_count), 32'd0);

      // No tokens at all: slip_count runs 1..9, 0, 1 across eleven slips.
      apply_reset("t7_rst");
      cyc = 0; slips = 0;
      bus_if.tmds_raw = FILLER;
      while (slips < 11 && cyc < SC + 10 * (SC + SS) + 4) begin
         step();
         cyc++;
         if (bus_if.bitslip === 1'b1) begin
            slips++;
            check_eq($sformatf("t7_count_%0d", slips), 32'(bus_if.slip_count), 32'(slips % 10));
         end
      end
      check_eq("t7_slips", 32'(slips), 32'd11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
